// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period, converts to an 8-bit duty code.
// Optional glitch filter is enabled by defining PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture #(
  parameter int CNT_W      = 16,
  parameter int MAX_PERIOD = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  input  logic             en,
  output logic [7:0]       duty,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             valid,
  output logic             stuck,
  output logic             overrun
);

  typedef enum logic {IDLE, MEASURE} state_e;

  localparam logic [CNT_W-1:0] MAXP = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic s1_q, s2_q;
  logic lvl, rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= pwm_in;
      s2_q <= s1_q;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic h1_q, h2_q, f_q, f_d;

  // Output follows the input only after three identical samples.
  always_comb begin
    f_d = f_q;
    if (s2_q == h1_q && h1_q == h2_q) f_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1_q <= 1'b0;
      h2_q <= 1'b0;
      f_q  <= 1'b0;
    end else begin
      h1_q <= s2_q;
      h2_q <= h1_q;
      f_q  <= f_d;
    end
  end

  assign lvl  = f_d;
  assign rise = f_d & ~f_q;
`else
  logic s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s3_q <= 1'b0;
    else        s3_q <= s2_q;
  end

  assign lvl  = s2_q;
  assign rise = s2_q & ~s3_q;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic             busy_q, busy_d;
  logic [3:0]       step_q, step_d;
  logic [CNT_W:0]   rem_q, rem_d;
  logic [CNT_W:0]   rem_sh;
  logic [CNT_W-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] hop_q, hop_d;
  logic [7:0]       quo_q, quo_d;
  logic             sat_q, sat_d;
  logic             pend_q, pend_d;
  logic             plvl_q, plvl_d;
  logic [7:0]       duty_q, duty_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             valid_q, valid_d;
  logic             stuck_q, stuck_d;
  logic             ovr_q, ovr_d;

  assign rem_sh = {rem_q[CNT_W-1:0], 1'b0};

  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    hi_d    = hi_q;
    busy_d  = busy_q;
    step_d  = step_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    hop_d   = hop_q;
    quo_d   = quo_q;
    sat_d   = sat_q;
    pend_d  = pend_q;
    plvl_d  = plvl_q;
    duty_d  = duty_q;
    hcnt_d  = hcnt_q;
    pcnt_d  = pcnt_q;
    valid_d = 1'b0;
    stuck_d = stuck_q;
    ovr_d   = 1'b0;
    if (!en) begin
      state_d = IDLE;
      per_d   = '0;
      hi_d    = '0;
      busy_d  = 1'b0;
      step_d  = '0;
      pend_d  = 1'b0;
    end else begin
      if (busy_q) begin
        if (step_q == 4'd8) begin
          busy_d  = 1'b0;
          valid_d = 1'b1;
          stuck_d = 1'b0;
          duty_d  = sat_q ? 8'hff : quo_q;
          hcnt_d  = hop_q;
          pcnt_d  = dvs_q;
        end else begin
          step_d = step_q + 4'd1;
          if (rem_sh >= {1'b0, dvs_q}) begin
            rem_d = rem_sh - {1'b0, dvs_q};
            quo_d = {quo_q[6:0], 1'b1};
          end else begin
            rem_d = rem_sh;
            quo_d = {quo_q[6:0], 1'b0};
          end
        end
      end else if (pend_q) begin
        pend_d  = 1'b0;
        valid_d = 1'b1;
        stuck_d = 1'b1;
        duty_d  = {8{plvl_q}};
        hcnt_d  = '0;
        pcnt_d  = '0;
      end
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = MEASURE;
            per_d   = ONE;
            hi_d    = ONE;
          end
        end
        MEASURE: begin
          if (rise) begin
            per_d = ONE;
            hi_d  = ONE;
            if (busy_q) begin
              ovr_d = 1'b1;
            end else begin
              busy_d = 1'b1;
              step_d = '0;
              rem_d  = {1'b0, hi_q};
              dvs_d  = per_q;
              hop_d  = hi_q;
              quo_d  = '0;
              sat_d  = (hi_q >= per_q);
            end
          end else if (per_q == MAXP) begin
            state_d = IDLE;
            per_d   = '0;
            hi_d    = '0;
            // Timeout is deferred until the divider has posted.
            if (busy_q) begin
              pend_d = 1'b1;
              plvl_d = lvl;
            end else begin
              valid_d = 1'b1;
              stuck_d = 1'b1;
              duty_d  = {8{lvl}};
              hcnt_d  = '0;
              pcnt_d  = '0;
            end
          end else begin
            per_d = per_q + ONE;
            if (lvl) hi_d = hi_q + ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      per_q   <= '0;
      hi_q    <= '0;
      busy_q  <= 1'b0;
      step_q  <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      hop_q   <= '0;
      quo_q   <= '0;
      sat_q   <= 1'b0;
      pend_q  <= 1'b0;
      plvl_q  <= 1'b0;
      duty_q  <= '0;
      hcnt_q  <= '0;
      pcnt_q  <= '0;
      valid_q <= 1'b0;
      stuck_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      hi_q    <= hi_d;
      busy_q  <= busy_d;
      step_q  <= step_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      hop_q   <= hop_d;
      quo_q   <= quo_d;
      sat_q   <= sat_d;
      pend_q  <= pend_d;
      plvl_q  <= plvl_d;
      duty_q  <= duty_d;
      hcnt_q  <= hcnt_d;
      pcnt_q  <= pcnt_d;
      valid_q <= valid_d;
      stuck_q <= stuck_d;
      ovr_q   <= ovr_d;
    end
  end

  assign duty       = duty_q;
  assign high_cnt   = hcnt_q;
  assign period_cnt = pcnt_q;
  assign valid      = valid_q;
  assign stuck      = stuck_q;
  assign overrun    = ovr_q;

endmodule
